// File: rtl/hpi_pkg.sv
// Shared register map, status layout and FSM encoding for the HPI responder.
package hpi_pkg;

    localparam logic [1:0] HPI_REG_DATA   = 2'd0;
    localparam logic [1:0] HPI_REG_MBX    = 2'd1;
    localparam logic [1:0] HPI_REG_ADDR   = 2'd2;
    localparam logic [1:0] HPI_REG_STATUS = 2'd3;

    localparam int STAT_OUT_FULL = 0;
    localparam int STAT_IN_FULL  = 1;
    localparam int STAT_OVERRUN  = 2;

    localparam logic [15:0] HPI_ADDR_INC = 16'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_FETCH,
        ST_RD_DRIVE,
        ST_WR_HOLD,
        ST_RECOVER
    } hpi_state_t;

    function automatic logic [15:0] status_word(input logic out_full,
                                                input logic in_full,
                                                input logic overrun);
        logic [15:0] w;
        w                = '0;
        w[STAT_OUT_FULL] = out_full;
        w[STAT_IN_FULL]  = in_full;
        w[STAT_OVERRUN]  = overrun;
        return w;
    endfunction

endpackage

// File: rtl/hpi_resp_dpram.sv
// True dual-port 2^AW x 16 word memory with registered reads.
// Port A serves the HPI master, port B the local firmware side.
module hpi_resp_dpram #(
    parameter int AW = 10
) (
    input  logic          sys_clk,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [15:0]   wdata_a,
    output logic [15:0]   rdata_a,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [15:0]   wdata_b,
    output logic [15:0]   rdata_b
);

    logic [15:0] mem [2**AW];

    // NOTE: the array and its read registers carry no reset; a reset would forbid RAM inference.
    always_ff @(posedge sys_clk) begin
        if (we_b) mem[addr_b] <= wdata_b;
        // Port A is written last so the HPI master wins a same-word collision.
        if (we_a) mem[addr_a] <= wdata_a;
        rdata_a <= mem[addr_a];
        rdata_b <= mem[addr_b];
    end

endmodule

// File: rtl/hpi_responder.sv
// Responder end of the CY7C67300 Host Port Interface backed by a dual-port word memory.
// Optional HPI_RESP_HRESET_EN: synchronized hpi_resetn returns the HPI side to its idle state.
module hpi_responder
    import hpi_pkg::*;
#(
    parameter int AW   = 10,
    parameter int SYNC = 2
) (
    input  logic          sys_clk,
    input  logic          usbreset,
    input  logic          hpi_csn,
    input  logic          hpi_oen,
    input  logic          hpi_wen,
    input  logic [1:0]    hpi_addr,
    inout  wire  [15:0]   hpi_d,
    output logic          hpi_int,
    input  logic          hpi_resetn,
    output logic [15:0]   loc_mbx_rx_data,
    output logic          loc_mbx_rx_valid,
    input  logic          loc_mbx_rx_ack,
    input  logic [15:0]   loc_mbx_tx_data,
    input  logic          loc_mbx_tx_valid,
    output logic          loc_mbx_tx_ready,
    input  logic [AW-1:0] loc_mem_addr,
    input  logic [15:0]   loc_mem_wdata,
    input  logic          loc_mem_we,
    output logic [15:0]   loc_mem_rdata
);

    logic [SYNC-1:0] csn_s, oen_s, wen_s;
    logic [1:0]      addr_p [SYNC];
    logic [15:0]     d_p    [SYNC];

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk or posedge usbreset) begin
        if (usbreset) begin
            csn_s <= '1;
            oen_s <= '1;
            wen_s <= '1;
            for (int i = 0; i < SYNC; i++) begin
                addr_p[i] <= '0;
                d_p[i]    <= '0;
            end
        end else begin
            csn_s     <= {csn_s[SYNC-2:0], hpi_csn};
            oen_s     <= {oen_s[SYNC-2:0], hpi_oen};
            wen_s     <= {wen_s[SYNC-2:0], hpi_wen};
            addr_p[0] <= hpi_addr;
            d_p[0]    <= hpi_d;
            for (int i = 1; i < SYNC; i++) begin
                addr_p[i] <= addr_p[i-1];
                d_p[i]    <= d_p[i-1];
            end
        end
    end

    logic        cs_n, rd_n, wr_n;
    logic [1:0]  reg_sel;
    logic [15:0] din;

    assign cs_n    = csn_s[SYNC-1];
    assign rd_n    = oen_s[SYNC-1];
    assign wr_n    = wen_s[SYNC-1];
    assign reg_sel = addr_p[SYNC-1];
    assign din     = d_p[SYNC-1];

    logic hreset_act;
`ifdef HPI_RESP_HRESET_EN
    logic [SYNC-1:0] hrst_s;

    always_ff @(posedge sys_clk or posedge usbreset) begin
        if (usbreset) hrst_s <= '1;
        else          hrst_s <= {hrst_s[SYNC-2:0], hpi_resetn};
    end

    assign hreset_act = !hrst_s[SYNC-1];
`else
    logic unused_hpi_resetn;
    assign unused_hpi_resetn = hpi_resetn;
    assign hreset_act        = 1'b0;
`endif

    hpi_state_t  state;
    logic [1:0]  acc_reg;
    logic [15:0] addr_reg, rd_q, wr_q, tx_word, rx_data, rd_mux, status, mem_rdata_a;
    logic        oe, rx_valid, out_full, overrun, mem_we_a;

    assign status   = status_word(out_full, rx_valid, overrun);
    assign mem_we_a = (state == ST_WR_HOLD) && (wr_n || cs_n) && (acc_reg == HPI_REG_DATA)
                      && !hreset_act;

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves rd_mux unassigned.
        rd_mux = mem_rdata_a;
        case (acc_reg)
            HPI_REG_MBX:    rd_mux = tx_word;
            HPI_REG_ADDR:   rd_mux = addr_reg;
            HPI_REG_STATUS: rd_mux = status;
            default:        ;
        endcase
    end

    always_ff @(posedge sys_clk or posedge usbreset) begin
        if (usbreset) begin
            state    <= ST_IDLE;
            acc_reg  <= HPI_REG_DATA;
            addr_reg <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            oe       <= 1'b0;
            tx_word  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            out_full <= 1'b0;
            overrun  <= 1'b0;
            hpi_int  <= 1'b0;
        end else if (hreset_act) begin
            state    <= ST_IDLE;
            oe       <= 1'b0;
            addr_reg <= '0;
            rx_valid <= 1'b0;
            out_full <= 1'b0;
            overrun  <= 1'b0;
            hpi_int  <= 1'b0;
        end else begin
            // Local ack comes first so a same-cycle master mailbox write keeps rx_valid set.
            if (loc_mbx_rx_ack) rx_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    acc_reg <= reg_sel;
                    wr_q    <= din;
                    if (!cs_n && !rd_n && wr_n)      state <= ST_RD_FETCH;
                    else if (!cs_n && !wr_n && rd_n) state <= ST_WR_HOLD;
                end
                ST_RD_FETCH: begin
                    rd_q  <= rd_mux;
                    oe    <= 1'b1;
                    state <= ST_RD_DRIVE;
                end
                ST_RD_DRIVE: begin
                    if (rd_n || cs_n) begin
                        oe    <= 1'b0;
                        state <= ST_RECOVER;
                        case (acc_reg)
                            HPI_REG_DATA:   addr_reg <= addr_reg + HPI_ADDR_INC;
                            HPI_REG_MBX: begin
                                out_full <= 1'b0;
                                hpi_int  <= 1'b0;
                            end
                            HPI_REG_STATUS: overrun <= 1'b0;
                            default:        ;
                        endcase
                    end
                end
                ST_WR_HOLD: begin
                    if (wr_n || cs_n) begin
                        state <= ST_RECOVER;
                        case (acc_reg)
                            HPI_REG_DATA: addr_reg <= addr_reg + HPI_ADDR_INC;
                            HPI_REG_MBX: begin
                                rx_data  <= wr_q;
                                rx_valid <= 1'b1;
                                if (rx_valid) overrun <= 1'b1;
                            end
                            HPI_REG_ADDR: addr_reg <= wr_q;
                            default:      ;
                        endcase
                    end else begin
                        wr_q <= din;
                    end
                end
                ST_RECOVER: begin
                    if (cs_n && rd_n && wr_n) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // A full mailbox blocks acceptance, so a draining read always wins before a new word lands.
            if (loc_mbx_tx_valid && !out_full) begin
                tx_word  <= loc_mbx_tx_data;
                out_full <= 1'b1;
                hpi_int  <= 1'b1;
            end
        end
    end

    assign hpi_d            = oe ? rd_q : {16{1'bz}};
    assign loc_mbx_rx_data  = rx_data;
    assign loc_mbx_rx_valid = rx_valid;
    assign loc_mbx_tx_ready = !out_full;

    hpi_resp_dpram #(.AW(AW)) u_dpram (
        .sys_clk (sys_clk),
        .we_a    (mem_we_a),
        .addr_a  (addr_reg[AW:1]),
        .wdata_a (wr_q),
        .rdata_a (mem_rdata_a),
        .we_b    (loc_mem_we),
        .addr_b  (loc_mem_addr),
        .wdata_b (loc_mem_wdata),
        .rdata_b (loc_mem_rdata)
    );

endmodule
